ibex_alu_arbiter: RTL and testbench
===================================

Name: ibex_alu_arbiter

Overview:
- Shares a single ibex_alu instance between NumReq independent requesters (e.g. a B-extension coprocessor port, a debug/self-test port, the main issue path).
- Arbitrates round-robin, sequences single- and multi-cycle ALU operations, and owns the imd_val intermediate registers.
- Returns one registered response per accepted request over a valid/ready channel.
- Sits between requesters and ibex_alu; ibex_alu stays purely combinational.

Parameters:
- NumReq, 3, number of requesters (2..8).
- MaxCycles, 8, watchdog limit on EXEC cycles per operation; used only with the optional feature.
- SrcW, $clog2(NumReq), width of the source index (derived, not overridable).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  NumReq  per-requester request valid.
- req_ready_o  output  NumReq  per-requester accept; one-hot or zero.
- req_op_i  input  NumReq*7  per-requester alu_op_e, packed; requester k uses slice [7k+:7].
- req_a_i  input  NumReq*32  per-requester operand A, packed.
- req_b_i  input  NumReq*32  per-requester operand B, packed.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response accept.
- rsp_src_o  output  SrcW  index of the requester this response belongs to.
- rsp_result_o  output  32  alu result_o.
- rsp_cmp_o  output  1  comparison_result_o.
- rsp_eq_o  output  1  is_equal_result_o.
- rsp_err_o  output  1  watchdog abort flag; constant 0 without the optional feature.
- alu_operator_o  output  7  to ibex_alu operator_i.
- alu_operand_a_o  output  32  to ibex_alu operand_a_i.
- alu_operand_b_o  output  32  to ibex_alu operand_b_i.
- alu_instr_first_cycle_o  output  1  to ibex_alu instr_first_cycle_i.
- alu_multdiv_sel_o  output  1  tied 0.
- alu_imd_val_q_o  output  2x32  to ibex_alu imd_val_q_i.
- alu_imd_val_d_i  input  2x32  from ibex_alu imd_val_d_o.
- alu_imd_val_we_i  input  2  from ibex_alu imd_val_we_o.
- alu_result_i  input  32  from ibex_alu result_o.
- alu_comparison_result_i  input  1  from ibex_alu comparison_result_o.
- alu_is_equal_result_i  input  1  from ibex_alu is_equal_result_o.

Behaviour:
- Reset values: state IDLE; all outputs 0; rr pointer 0; imd_val regs 0; captured op/operands 0. alu_operator_o resets to ALU_ADD (encoding 0).
- FSM states:
  - IDLE: req_ready_o combinationally grants the first valid requester at or after the rr pointer, wrapping modulo NumReq. On handshake: capture op, a, b and src; rr pointer <= src+1 (mod NumReq); go to EXEC with first=1.
  - EXEC: ALU inputs come from captured registers.
    - alu_instr_first_cycle_o=1 only in the first EXEC cycle.
    - Each cycle, imd_val_q[i] <= imd_val_d_i[i] where alu_imd_val_we_i[i]=1.
    - A cycle with alu_imd_val_we_i==2'b00 is the completion cycle: register result, cmp and eq; go to RESP.
    - Single-cycle ops (e.g. ALU_EQ, ALU_ADD) complete in their first EXEC cycle.
  - RESP: rsp_valid_o=1 with registered fields held stable until rsp_ready_i=1, then go to IDLE. The pipeline is not overlapped: the next grant occurs in IDLE.
- Outside EXEC, alu_instr_first_cycle_o=0.
- Latency: request handshake at cycle T -> rsp_valid_o at T+1+E, where E = number of EXEC cycles (E=1 for single-cycle ops).
- Throughput: one op per 2+E cycles, plus backpressure.
- req_ready_o is 0 in EXEC and RESP; a requester must hold valid and payload stable until ready.
- imd_val regs are cleared to 0 on each new grant so no state leaks between requesters.
- Simultaneous requests: exactly one grant; the losers keep waiting. Starvation-free, each requester waits at most NumReq-1 grants.
- Out-of-range rr pointer never occurs; pointer arithmetic wraps explicitly for non-power-of-2 NumReq.
- Reset mid-operation: immediate return to IDLE; the response is dropped; no rsp_valid_o after reset release until a new grant.

Optional Feature:
- Macro: IBEX_ALU_ARB_WATCHDOG_EN.
- Defined: an EXEC cycle counter is compared against MaxCycles.
  - If MaxCycles EXEC cycles pass without a completion cycle, go to RESP with rsp_err_o=1, rsp_result_o=0, rsp_cmp_o=0 and rsp_eq_o=0.
  - The counter clears on each grant.
- Not defined: no counter; EXEC waits indefinitely; rsp_err_o tied 0.

Test Plan:
- Requester 0, ALU_EQ, a=18, b=18 -> rsp_valid 2 cycles after handshake, rsp_eq=1, rsp_cmp=1, rsp_src=0. Repeat with a=18, b=3 -> rsp_eq=0.
- All three requesters assert ALU_ADD together (1+1, 2+2, 3+3) from reset -> grant order 0,1,2 with results 2,4,6. Requester 0 then re-requests while 1 is pending -> 1 is served before 0.
- ALU_CMOV (two-cycle ternary op, RV32BFull) -> alu_instr_first_cycle high for exactly 1 cycle; imd_val_q loaded from imd_val_d; E=2; result matches the golden model.
- rsp_ready_i held low for 5 cycles -> rsp_valid and all fields stable throughout; req_ready stays 0; completes on release.
- Assert rst_ni low during EXEC of an ALU_CMOV -> all outputs 0 asynchronously; no spurious response after release.
- With IBEX_ALU_ARB_WATCHDOG_EN and a stub ALU forcing imd_val_we=2'b01 -> rsp_err=1 after exactly MaxCycles=8 EXEC cycles.

Source files
------------

// File: rtl/ibex_alu_arbiter.sv
// Round-robin arbiter that shares one combinational ibex_alu between NumReq requesters.
// Define IBEX_ALU_ARB_WATCHDOG_EN to abort operations that exceed MaxCycles EXEC cycles.
module ibex_alu_arbiter #(
  parameter int unsigned NumReq    = 3,
  parameter int unsigned MaxCycles = 8,
  localparam int unsigned SrcW     = $clog2(NumReq)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumReq-1:0]    req_valid_i,
  output logic [NumReq-1:0]    req_ready_o,
  input  logic [NumReq*7-1:0]  req_op_i,
  input  logic [NumReq*32-1:0] req_a_i,
  input  logic [NumReq*32-1:0] req_b_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [SrcW-1:0]      rsp_src_o,
  output logic [31:0]          rsp_result_o,
  output logic                 rsp_cmp_o,
  output logic                 rsp_eq_o,
  output logic                 rsp_err_o,
  output logic [6:0]           alu_operator_o,
  output logic [31:0]          alu_operand_a_o,
  output logic [31:0]          alu_operand_b_o,
  output logic                 alu_instr_first_cycle_o,
  output logic                 alu_multdiv_sel_o,
  output logic [1:0][31:0]     alu_imd_val_q_o,
  input  logic [1:0][31:0]     alu_imd_val_d_i,
  input  logic [1:0]           alu_imd_val_we_i,
  input  logic [31:0]          alu_result_i,
  input  logic                 alu_comparison_result_i,
  input  logic                 alu_is_equal_result_i
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e            r_state;
  logic [SrcW-1:0]   r_rrPtr;
  logic [SrcW-1:0]   r_src;
  logic [6:0]        r_op;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic              r_first;
  logic [1:0][31:0]  r_imdVal;
  logic              r_rspValid;
  logic [31:0]       r_result;
  logic              r_cmp;
  logic              r_eq;

  logic              w_found;
  logic [SrcW-1:0]   w_grantIdx;
  logic [SrcW:0]     w_idx;
  logic              w_fire;
  logic [SrcW-1:0]   w_nextPtr;
  logic [6:0]        w_op;
  logic [31:0]       w_a;
  logic [31:0]       w_b;

  // Search starts at the rr pointer; the extra index bit holds ptr+offset before the explicit wrap.
  always_comb begin
    w_found    = 1'b0;
    w_grantIdx = '0;
    w_idx      = '0;
    for (int off = 0; off < int'(NumReq); off++) begin
      w_idx = {1'b0, r_rrPtr} + (SrcW+1)'(off);
      if (w_idx >= (SrcW+1)'(NumReq)) w_idx = w_idx - (SrcW+1)'(NumReq);
      if (!w_found && req_valid_i[w_idx[SrcW-1:0]]) begin
        w_found    = 1'b1;
        w_grantIdx = w_idx[SrcW-1:0];
      end
    end
  end

  assign req_ready_o = (r_state == S_IDLE && w_found && rst_ni)
                       ? ({{(NumReq-1){1'b0}}, 1'b1} << w_grantIdx) : '0;
  assign w_fire      = |req_ready_o;
  assign w_nextPtr   = (w_grantIdx == SrcW'(NumReq - 1)) ? '0 : w_grantIdx + SrcW'(1);
  assign w_op        = req_op_i[int'(w_grantIdx)*7 +: 7];
  assign w_a         = req_a_i[int'(w_grantIdx)*32 +: 32];
  assign w_b         = req_b_i[int'(w_grantIdx)*32 +: 32];

`ifdef IBEX_ALU_ARB_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(MaxCycles + 1);
  logic [CntW-1:0] r_cnt;
  logic            r_err;
  assign rsp_err_o = r_err;
`else
  logic w_unusedMaxCycles;
  assign w_unusedMaxCycles = (MaxCycles != 0);
  assign rsp_err_o         = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_rrPtr    <= '0;
      r_src      <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_first    <= 1'b0;
      r_imdVal   <= '0;
      r_rspValid <= 1'b0;
      r_result   <= '0;
      r_cmp      <= 1'b0;
      r_eq       <= 1'b0;
`ifdef IBEX_ALU_ARB_WATCHDOG_EN
      r_cnt      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_op     <= w_op;
            r_a      <= w_a;
            r_b      <= w_b;
            r_src    <= w_grantIdx;
            r_rrPtr  <= w_nextPtr;
            r_imdVal <= '0;
            r_first  <= 1'b1;
            r_state  <= S_EXEC;
`ifdef IBEX_ALU_ARB_WATCHDOG_EN
            r_cnt    <= '0;
            r_err    <= 1'b0;
`endif
          end
        end
        S_EXEC: begin
          r_first <= 1'b0;
          for (int i = 0; i < 2; i++) begin
            if (alu_imd_val_we_i[i]) r_imdVal[i] <= alu_imd_val_d_i[i];
          end
          // A cycle without intermediate writes is the one where the ALU result is final.
          if (alu_imd_val_we_i == 2'b00) begin
            r_result   <= alu_result_i;
            r_cmp      <= alu_comparison_result_i;
            r_eq       <= alu_is_equal_result_i;
            r_rspValid <= 1'b1;
            r_state    <= S_RESP;
          end
`ifdef IBEX_ALU_ARB_WATCHDOG_EN
          else if (r_cnt == CntW'(MaxCycles - 1)) begin
            r_result   <= '0;
            r_cmp      <= 1'b0;
            r_eq       <= 1'b0;
            r_err      <= 1'b1;
            r_rspValid <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_rspValid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid_o             = r_rspValid;
  assign rsp_src_o               = r_src;
  assign rsp_result_o            = r_result;
  assign rsp_cmp_o               = r_cmp;
  assign rsp_eq_o                = r_eq;
  assign alu_operator_o          = r_op;
  assign alu_operand_a_o         = r_a;
  assign alu_operand_b_o         = r_b;
  assign alu_instr_first_cycle_o = r_first;
  assign alu_multdiv_sel_o       = 1'b0;
  assign alu_imd_val_q_o         = r_imdVal;

endmodule

// File: tb/tb_ibex_alu_arbiter.sv
// Self-checking bench for ibex_alu_arbiter: a stub ALU answers the arbiter, a scoreboard
// holds expected responses in grant order. Define IBEX_ALU_ARB_WATCHDOG_EN to run the abort test.
module tb_ibex_alu_arbiter;

  localparam int NREQ = 3;
  localparam int SRCW = 2;
  localparam int MAXC = 8;

  // Stub encodings; the arbiter treats operator bits as opaque.
  localparam logic [6:0] OP_ADD   = 7'd0;
  localparam logic [6:0] OP_EQ    = 7'd23;
  localparam logic [6:0] OP_CMOV  = 7'd50;
  localparam logic [6:0] OP_STUCK = 7'd127;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } reqT;

  typedef struct {
    logic [SRCW-1:0] src;
    logic [31:0]     result;
    logic            cmp;
    logic            eq;
    logic            err;
    int              execCycles;
    int              hsCycle;
  } expT;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [NREQ-1:0]    reqValid = '0;
  logic [NREQ-1:0]    reqReady;
  logic [6:0]         reqOp [NREQ];
  logic [31:0]        reqA  [NREQ];
  logic [31:0]        reqB  [NREQ];
  logic [NREQ*7-1:0]  opBus;
  logic [NREQ*32-1:0] aBus;
  logic [NREQ*32-1:0] bBus;
  logic               rspValid;
  logic               rspReady = 1'b1;
  logic [SRCW-1:0]    rspSrc;
  logic [31:0]        rspResult;
  logic               rspCmp;
  logic               rspEq;
  logic               rspErr;
  logic [6:0]         aluOp;
  logic [31:0]        aluA;
  logic [31:0]        aluB;
  logic               aluFirst;
  logic               aluMultdiv;
  logic [1:0][31:0]   aluImdQ;
  logic [1:0][31:0]   aluImdD;
  logic [1:0]         aluImdWe;
  logic [31:0]        aluResult;
  logic               aluCmp;
  logic               aluEq;

  reqT reqQ [NREQ][$];
  expT sb[$];
  int  grantLog[$];
  logic [NREQ-1:0] lastGrant = '0;
  int  cyc = 0;
  int  holdLeft = 0;
  int  firstCount = 0;
  int  readyViol = 0;
  bit  headSeen = 0;
  int  assertCount = 0;
  int  failCount = 0;

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      reqOp[k] = '0;
      reqA[k]  = '0;
      reqB[k]  = '0;
    end
  end

  always_comb begin
    opBus = '0;
    aBus  = '0;
    bBus  = '0;
    for (int k = 0; k < NREQ; k++) begin
      opBus[k*7 +: 7]  = reqOp[k];
      aBus[k*32 +: 32] = reqA[k];
      bBus[k*32 +: 32] = reqB[k];
    end
  end

  // Stub ALU: CMOV parks operand A in imd_val[0] on its first cycle and selects from it on the second.
  always_comb begin
    aluResult = '0;
    aluCmp    = 1'b0;
    aluEq     = (aluA == aluB);
    aluImdWe  = 2'b00;
    aluImdD   = '0;
    case (aluOp)
      OP_ADD: aluResult = aluA + aluB;
      OP_EQ: begin
        aluResult = {31'b0, aluEq};
        aluCmp    = aluEq;
      end
      OP_CMOV: begin
        if (aluFirst) begin
          aluImdWe   = 2'b01;
          aluImdD[0] = aluA;
        end else begin
          aluResult = (aluB != 0) ? aluImdQ[0] : ~aluImdQ[0];
        end
      end
      OP_STUCK: begin
        aluImdWe   = 2'b01;
        aluImdD[0] = aluA;
      end
      default: aluResult = '0;
    endcase
  end

  ibex_alu_arbiter #(.NumReq(NREQ), .MaxCycles(MAXC)) dut (
    .clk_i                   (clk),
    .rst_ni                  (rstN),
    .req_valid_i             (reqValid),
    .req_ready_o             (reqReady),
    .req_op_i                (opBus),
    .req_a_i                 (aBus),
    .req_b_i                 (bBus),
    .rsp_valid_o             (rspValid),
    .rsp_ready_i             (rspReady),
    .rsp_src_o               (rspSrc),
    .rsp_result_o            (rspResult),
    .rsp_cmp_o               (rspCmp),
    .rsp_eq_o                (rspEq),
    .rsp_err_o               (rspErr),
    .alu_operator_o          (aluOp),
    .alu_operand_a_o         (aluA),
    .alu_operand_b_o         (aluB),
    .alu_instr_first_cycle_o (aluFirst),
    .alu_multdiv_sel_o       (aluMultdiv),
    .alu_imd_val_q_o         (aluImdQ),
    .alu_imd_val_d_i         (aluImdD),
    .alu_imd_val_we_i        (aluImdWe),
    .alu_result_i            (aluResult),
    .alu_comparison_result_i (aluCmp),
    .alu_is_equal_result_i   (aluEq)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic expT model(input logic [SRCW-1:0] src, input logic [6:0] op,
                                input logic [31:0] a, input logic [31:0] b);
    expT e;
    e.src = src; e.result = '0; e.cmp = 1'b0; e.eq = (a == b); e.err = 1'b0;
    e.execCycles = 1; e.hsCycle = cyc;
    case (op)
      OP_ADD: e.result = a + b;
      OP_EQ: begin
        e.result = {31'b0, a == b};
        e.cmp    = (a == b);
      end
      OP_CMOV: begin
        e.result     = (b != 0) ? a : ~a;
        e.execCycles = 2;
      end
      OP_STUCK: begin
        e.eq         = 1'b0;
        e.err        = 1'b1;
        e.execCycles = MAXC;
      end
      default: e.result = '0;
    endcase
    return e;
  endfunction

  task automatic applyStimulus(input int src, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    reqT r;
    r.op = op; r.a = a; r.b = b;
    reqQ[src].push_back(r);
  endtask

  function automatic bit busy();
    bit any = (sb.size() > 0) || (reqValid != 0);
    for (int k = 0; k < NREQ; k++) if (reqQ[k].size() > 0) any = 1;
    return any;
  endfunction

  // Observation runs #1 after the falling edge; whatever is seen here is what the next rising edge commits.
  task automatic observe();
    expT e;
    if (aluFirst) begin
      firstCount++;
      checkOutput("imd_clear_on_grant", aluImdQ[0] | aluImdQ[1], 32'h0);
    end
    if ($countones(reqReady) > 1 || (reqReady & ~reqValid) != 0) readyViol++;
    if (rspValid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_rsp", {31'b0, rspValid}, 32'h0);
      end else begin
        e = sb[0];
        if (!headSeen) begin
          headSeen = 1;
          checkOutput("latency", cyc - e.hsCycle, 1 + e.execCycles);
        end
        if (rspReady) begin
          checkOutput("rsp_src", rspSrc, e.src);
          checkOutput("rsp_result", rspResult, e.result);
          checkOutput("rsp_cmp", rspCmp, e.cmp);
          checkOutput("rsp_eq", rspEq, e.eq);
          checkOutput("rsp_err", rspErr, e.err);
          checkOutput("first_pulses", firstCount, 1);
          firstCount = 0;
          headSeen = 0;
          void'(sb.pop_front());
        end else begin
          checkOutput("hold_result", rspResult, e.result);
          checkOutput("hold_src", rspSrc, e.src);
          checkOutput("hold_eq", rspEq, e.eq);
          checkOutput("hold_req_ready", reqReady, 0);
          holdLeft--;
        end
      end
    end
    lastGrant = reqReady & reqValid;
    for (int k = 0; k < NREQ; k++) begin
      if (lastGrant[k]) begin
        sb.push_back(model(SRCW'(k), reqOp[k], reqA[k], reqB[k]));
        grantLog.push_back(k);
      end
    end
  endtask

  task automatic tick();
    reqT r;
    @(negedge clk);
    for (int k = 0; k < NREQ; k++) begin
      if (lastGrant[k]) reqValid[k] = 1'b0;
      if (!reqValid[k] && reqQ[k].size() > 0) begin
        r = reqQ[k].pop_front();
        reqValid[k] = 1'b1;
        reqOp[k] = r.op;
        reqA[k]  = r.a;
        reqB[k]  = r.b;
      end
    end
    rspReady = (holdLeft == 0);
    #1;
    cyc++;
    observe();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_done", {31'b0, busy()}, 32'h0);
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, "_rsp_valid"}, rspValid, 0);
    checkOutput({phase, "_req_ready"}, reqReady, 0);
    checkOutput({phase, "_rsp_fields"}, rspResult | {29'b0, rspCmp, rspEq, rspErr}, 0);
    checkOutput({phase, "_rsp_src"}, rspSrc, 0);
    checkOutput({phase, "_alu_op"}, aluOp, 0);
    checkOutput({phase, "_alu_operands"}, aluA | aluB, 0);
    checkOutput({phase, "_alu_first"}, {31'b0, aluFirst | aluMultdiv}, 0);
    checkOutput({phase, "_imd_q"}, aluImdQ[0] | aluImdQ[1], 0);
  endtask

  initial begin
    int n;
    int spur;
    $display("[TB] ibex_alu_arbiter bench start");
    reqValid = '1;
    repeat (2) tick();
    checkResetOutputs("reset");
    reqValid = '0;
    rstN = 1'b1;

    $display("[TB] three simultaneous ADD requests, requester 0 re-requests");
    grantLog.delete();
    applyStimulus(0, OP_ADD, 32'd1, 32'd1);
    applyStimulus(1, OP_ADD, 32'd2, 32'd2);
    applyStimulus(2, OP_ADD, 32'd3, 32'd3);
    applyStimulus(0, OP_ADD, 32'd10, 32'd10);
    drain(100);
    checkOutput("grant_count", grantLog.size(), 4);
    checkOutput("grant_order0", grantLog[0], 0);
    checkOutput("grant_order1", grantLog[1], 1);
    checkOutput("grant_order2", grantLog[2], 2);
    checkOutput("grant_order3", grantLog[3], 0);

    $display("[TB] EQ compare, equal and unequal");
    applyStimulus(0, OP_EQ, 32'd18, 32'd18);
    drain(20);
    applyStimulus(0, OP_EQ, 32'd18, 32'd3);
    drain(20);

    $display("[TB] two-cycle CMOV");
    applyStimulus(1, OP_CMOV, 32'h1234_5678, 32'd1);
    drain(20);
    applyStimulus(2, OP_CMOV, 32'hCAFE_0001, 32'd0);
    drain(20);

    $display("[TB] response backpressure");
    holdLeft = 5;
    applyStimulus(0, OP_ADD, 32'd100, 32'd23);
    applyStimulus(2, OP_ADD, 32'hFFFF_FFFF, 32'd6);
    drain(60);
    checkOutput("hold_consumed", holdLeft, 0);

    $display("[TB] reset during CMOV execution");
    applyStimulus(1, OP_CMOV, 32'hA5A5_0F0F, 32'd1);
    n = 0;
    while (lastGrant == 0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("rst_grant_seen", {31'b0, lastGrant != 0}, 1);
    tick();
    checkOutput("rst_in_exec_first", {31'b0, aluFirst}, 1);
    #2 rstN = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    sb.delete();
    headSeen = 0;
    firstCount = 0;
    lastGrant = '0;
    repeat (2) tick();
    rstN = 1'b1;
    spur = 0;
    repeat (6) begin
      tick();
      if (rspValid) spur++;
    end
    checkOutput("no_rsp_after_reset", spur, 0);
    applyStimulus(2, OP_ADD, 32'd7, 32'd8);
    drain(20);

`ifdef IBEX_ALU_ARB_WATCHDOG_EN
    $display("[TB] watchdog abort on stuck operation");
    applyStimulus(1, OP_STUCK, 32'd1, 32'd2);
    drain(40);
    applyStimulus(0, OP_ADD, 32'd4, 32'd5);
    drain(20);
`endif

    checkOutput("ready_onehot", readyViol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed cycle %0d expected completion", cyc);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
